// File: rtl/lut_mem_arb_pkg.sv
// Shared types for the LUT memory arbiter: FSM states and requester identities.
package lut_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_USER = 1'b1
    } requester_t;

    // Reset value of last_grant: pointing at the user makes the host win the first contention.
    localparam requester_t RESET_LAST_GRANT = REQ_USER;

    function automatic requester_t other_requester(input requester_t id);
        return (id == REQ_HOST) ? REQ_USER : REQ_HOST;
    endfunction

endpackage

// File: rtl/lut_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin select between the host and user request lines.
module rr_pick2
    import lut_mem_arb_pkg::*;
(
    input  logic       i_host_req,
    input  logic       i_user_req,
    input  requester_t i_last_grant,
    output logic       o_grant_valid,
    output requester_t o_grant_id
);

    always_comb begin
        o_grant_valid = i_host_req | i_user_req;
        o_grant_id    = REQ_HOST;
        if (i_host_req && i_user_req) begin
            o_grant_id = other_requester(i_last_grant);
        end else if (i_user_req) begin
            o_grant_id = REQ_USER;
        end
    end

endmodule

// File: rtl/lut_mem_arbiter.sv
// Round-robin arbiter sharing one single-port LUT memory between the host bus and a user port.
// Every access runs IDLE -> ACCESS (-> RESP for reads) with all outputs registered.
module lut_mem_arbiter
    import lut_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,

    input  logic                  user_req,
    input  logic                  user_we,
    input  logic [ADDR_WIDTH-1:0] user_addr,
    input  logic [DATA_WIDTH-1:0] user_wdata,
    output logic                  user_ack,
    output logic                  user_rvalid,
    output logic [DATA_WIDTH-1:0] user_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy,
    output logic                  last_grant
);

    state_t                r_state;
    requester_t            r_last_grant;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_we;
    logic                  r_host_ack;
    logic                  r_user_ack;
    logic                  r_host_rvalid;
    logic                  r_user_rvalid;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic [DATA_WIDTH-1:0] r_user_rdata;

    logic                  w_grant_valid;
    requester_t            w_grant_id;
    logic                  w_win_we;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;

    rr_pick2 u_pick (
        .i_host_req    (host_req),
        .i_user_req    (user_req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    always_comb begin
        w_win_we    = host_we;
        w_win_addr  = host_addr;
        w_win_wdata = host_wdata;
        if (w_grant_id == REQ_USER) begin
            w_win_we    = user_we;
            w_win_addr  = user_addr;
            w_win_wdata = user_wdata;
        end
    end

    // last_grant doubles as the owner of the in-flight transaction in ACCESS and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_grant  <= RESET_LAST_GRANT;
            r_busy        <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_host_ack    <= 1'b0;
            r_user_ack    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_user_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_user_rdata  <= '0;
        end else begin
            r_host_ack    <= 1'b0;
            r_user_ack    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_user_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_mem_addr   <= w_win_addr;
                        r_mem_wdata  <= w_win_wdata;
                        r_mem_we     <= w_win_we;
                        r_last_grant <= w_grant_id;
                        r_host_ack   <= (w_grant_id == REQ_HOST);
                        r_user_ack   <= (w_grant_id == REQ_USER);
                        r_busy       <= 1'b1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_we <= 1'b0;
                    if (r_mem_we) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (r_last_grant == REQ_HOST) begin
                        r_host_rdata  <= mem_rdata;
                        r_host_rvalid <= 1'b1;
                    end else begin
                        r_user_rdata  <= mem_rdata;
                        r_user_rvalid <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign host_ack    = r_host_ack;
    assign user_ack    = r_user_ack;
    assign host_rvalid = r_host_rvalid;
    assign user_rvalid = r_user_rvalid;
    assign host_rdata  = r_host_rdata;
    assign user_rdata  = r_user_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign busy        = r_busy;
    assign last_grant  = r_last_grant;

endmodule
